inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer_pkg.sv | 25 ++
 rtl/ib_storage.sv | 35 +++
 rtl/inst_buffer.sv | 92 +++++++++
 tb/tb_inst_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types for the instruction buffer: dispatch packet layout,
// default depth (`IB_SZ) and the head/tail pointer type.
`ifndef IB_SZ
`define IB_SZ 8
`endif

package inst_buffer_pkg;

  localparam int unsigned IB_DEPTH_DEFAULT = `IB_SZ;

  // Pointer type sized for the default depth.
  typedef logic [$clog2(IB_DEPTH_DEFAULT)-1:0] IB_PTR;

  // Decoded instruction handed from fetch/decode to dispatch.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  dest_reg_idx;
    logic        valid;
  } DP_PACKET;

endpackage

// File: rtl/ib_storage.sv
// Instruction buffer entry storage: DEPTH x DP_PACKET register array with
// one write port, one asynchronous read port and asynchronous reset-clear.
module ib_storage
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  DP_PACKET                 i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output DP_PACKET                 o_rd_data
);

  DP_PACKET r_mem [DEPTH];

  // Entry write; reset wipes every entry regardless of the clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Asynchronous read of the head entry.
  always_comb begin
    o_rd_data = r_mem[i_rd_addr];
  end

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch/decode and dispatch: circular FIFO with
// head/tail pointers and an occupancy counter. Squash flushes everything at
// the next edge and masks both handshakes while asserted.
// Optional macro INST_BUFFER_BYPASS_EN: when empty, an incoming packet is
// presented to dispatch in the same cycle and is not written if taken.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = IB_DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   if_valid,
  input  DP_PACKET               if_packet,
  output logic                   ib_ready,
  output logic                   dp_valid,
  output DP_PACKET               dp_packet,
  input  logic                   dp_ready,
  input  logic                   squash,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;

  logic     w_empty;
  logic     w_full;
  logic     w_bypass;
  logic     w_bypass_take;
  logic     w_push;
  logic     w_pop;
  DP_PACKET w_head_pkt;

  ib_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_push),
    .i_wr_addr (r_tail),
    .i_wr_data (if_packet),
    .i_rd_addr (r_head),
    .o_rd_data (w_head_pkt)
  );

  // Handshake decode and dispatch output selection.
  always_comb begin
    w_empty       = (r_count == '0);
    w_full        = (r_count == FULL_CNT);
    w_bypass      = 1'b0;
`ifdef INST_BUFFER_BYPASS_EN
    w_bypass      = w_empty && if_valid && !squash;
`endif
    // A bypassed packet taken by dispatch never touches storage.
    w_bypass_take = w_bypass && dp_ready;
    ib_ready      = !w_full && !squash;
    dp_valid      = (!w_empty || w_bypass) && !squash;
    w_push        = if_valid && ib_ready && !w_bypass_take;
    w_pop         = dp_valid && dp_ready && !w_empty;
    dp_packet     = '0;
    if (dp_valid) begin
      dp_packet = w_bypass ? if_packet : w_head_pkt;
    end
    count         = r_count;
  end

  // Pointer and occupancy update; squash overrides any push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed testbench for inst_buffer (DEPTH=8). Covers reset, fill/overflow,
// wrap-around streaming, simultaneous push/pop, squash and async reset.
// Bypass expectations are selected by INST_BUFFER_BYPASS_EN.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic     clock    = 1'b0;
  logic     reset    = 1'b1;
  logic     if_valid = 1'b0;
  logic     dp_ready = 1'b0;
  logic     squash   = 1'b0;
  DP_PACKET if_packet;
  logic     ib_ready;
  logic     dp_valid;
  DP_PACKET dp_packet;
  logic [$clog2(DEPTH):0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx;

  always #5 clock = ~clock;

  inst_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .if_valid  (if_valid),
    .if_packet (if_packet),
    .ib_ready  (ib_ready),
    .dp_valid  (dp_valid),
    .dp_packet (dp_packet),
    .dp_ready  (dp_ready),
    .squash    (squash),
    .count     (count)
  );

  function automatic DP_PACKET mk(input logic [31:0] pc);
    DP_PACKET p;
    p              = '0;
    p.pc           = pc;
    p.npc          = pc + 32'd4;
    p.inst         = pc ^ 32'h1300_0013;
    p.dest_reg_idx = pc[6:2];
    p.valid        = 1'b1;
    return p;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    if_valid  = 1'b1;
    if_packet = mk(pc);
    tick();
    if_valid  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    if_packet = '0;

    // Reset state, during and after reset
    #2;
    check("rst_count",    count,     0);
    check("rst_ib_ready", ib_ready,  1);
    check("rst_dp_valid", dp_valid,  0);
    check("rst_dp_pkt",   dp_packet, 0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_count",    count,    0);
    check("post_rst_ib_ready", ib_ready, 1);
    check("post_rst_dp_valid", dp_valid, 0);

    // dp_ready while empty changes nothing
    dp_ready = 1'b1;
    tick();
    check("idle_pop_count", count,    0);
    check("idle_pop_ready", ib_ready, 1);
    dp_ready = 1'b0;

`ifdef INST_BUFFER_BYPASS_EN
    // Bypass taken: same-cycle presentation, no storage
    if_valid = 1'b1; if_packet = mk(32'h40); dp_ready = 1'b1;
    #1;
    check("byp_dp_valid", dp_valid,  1);
    check("byp_dp_pkt",   dp_packet, mk(32'h40));
    check("byp_count",    count,     0);
    tick();
    if_valid = 1'b0; dp_ready = 1'b0;
    #1;
    check("byp_after_count", count,    0);
    check("byp_after_valid", dp_valid, 0);
    // Bypass not taken: normal push
    if_valid = 1'b1; if_packet = mk(32'h44);
    tick();
    if_valid = 1'b0;
    check("byp_nt_count", count,     1);
    check("byp_nt_pkt",   dp_packet, mk(32'h44));
    dp_ready = 1'b1;
    tick();
    dp_ready = 1'b0;
    check("byp_nt_drain", count, 0);
`else
    // One-cycle push-to-valid latency
    if_valid = 1'b1; if_packet = mk(32'h40); dp_ready = 1'b0;
    #1;
    check("lat_same_cycle_valid", dp_valid, 0);
    tick();
    if_valid = 1'b0;
    check("lat_next_valid", dp_valid,  1);
    check("lat_next_pkt",   dp_packet, mk(32'h40));
    check("lat_next_count", count,     1);
    dp_ready = 1'b1;
    tick();
    dp_ready = 1'b0;
    check("lat_drain", count, 0);
`endif

    // Fill to capacity, overflow push ignored, no push-through when full
    dp_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'(i * 4));
    if_valid = 1'b1; if_packet = mk(32'h20);
    #1;
    check("full_count",    count,     8);
    check("full_ib_ready", ib_ready,  0);
    check("full_dp_valid", dp_valid,  1);
    check("full_head",     dp_packet, mk(32'h0));
    tick();
    check("overflow_count", count, 8);
    if_packet = mk(32'h24); dp_ready = 1'b1;
    #1;
    check("full_pp_head", dp_packet, mk(32'h0));
    tick();
    if_valid = 1'b0;
    check("full_pp_count", count, 7);
    for (int i = 1; i < 8; i++) begin
      #1;
      check("fill_order_valid", dp_valid,  1);
      check("fill_order_pkt",   dp_packet, mk(32'(i * 4)));
      tick();
    end
    check("fill_drained_count", count,     0);
    check("fill_drained_valid", dp_valid,  0);
    check("fill_drained_pkt",   dp_packet, 0);
    dp_ready = 1'b0;

    // Streaming 20 packets across pointer wrap
    exp_idx  = 0;
    dp_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if_valid  = (c < 20);
      if_packet = mk(32'h100 + 32'(c * 4));
      #1;
      if (dp_valid) begin
        check("wrap_pkt", dp_packet, mk(32'h100 + 32'(exp_idx * 4)));
        exp_idx++;
      end
`ifdef INST_BUFFER_BYPASS_EN
      check("wrap_count_zero", count, 0);
`else
      check("wrap_count_le1", (count <= 1), 1);
`endif
      tick();
    end
    if_valid = 1'b0; dp_ready = 1'b0;
    check("wrap_total_pops", exp_idx, 20);
    check("wrap_end_count",  count,   0);

    // Simultaneous push and pop at count 3
    push(32'h200); push(32'h204); push(32'h208);
    if_valid = 1'b1; if_packet = mk(32'h20C); dp_ready = 1'b1;
    #1;
    check("pp_count_before", count,     3);
    check("pp_head_before",  dp_packet, mk(32'h200));
    tick();
    if_valid = 1'b0; dp_ready = 1'b0;
    check("pp_count_after", count,     3);
    check("pp_head_after",  dp_packet, mk(32'h204));
    dp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      check("pp_drain_pkt", dp_packet, mk(32'h200 + 32'(i * 4)));
      tick();
    end
    dp_ready = 1'b0;
    check("pp_drain_count", count, 0);

    // Squash at count 5 with concurrent push and pop
    for (int i = 0; i < 5; i++) push(32'h300 + 32'(i * 4));
    if_valid = 1'b1; if_packet = mk(32'h500); dp_ready = 1'b1; squash = 1'b1;
    #1;
    check("sq_count_during", count,     5);
    check("sq_ib_ready",     ib_ready,  0);
    check("sq_dp_valid",     dp_valid,  0);
    check("sq_dp_pkt",       dp_packet, 0);
    tick();
    squash = 1'b0; if_valid = 1'b0; dp_ready = 1'b0;
    #1;
    check("sq_after_count", count,    0);
    check("sq_after_valid", dp_valid, 0);
    check("sq_after_ready", ib_ready, 1);
    push(32'h600);
    check("sq_next_pkt",   dp_packet, mk(32'h600));
    check("sq_next_count", count,     1);
    dp_ready = 1'b1;
    tick();
    dp_ready = 1'b0;
    check("sq_drain_count", count, 0);

    // Asynchronous reset between edges at count 4
    for (int i = 0; i < 4; i++) push(32'h700 + 32'(i * 4));
    #1;
    check("ar_count_before", count, 4);
    #1;
    reset = 1'b1;
    #1;
    check("ar_count",    count,     0);
    check("ar_dp_valid", dp_valid,  0);
    check("ar_dp_pkt",   dp_packet, 0);
    check("ar_ib_ready", ib_ready,  1);
    #1;
    reset = 1'b0;
    tick();
    check("ar_after_count", count,    0);
    check("ar_after_valid", dp_valid, 0);
    push(32'h800);
    check("ar_resume_pkt", dp_packet, mk(32'h800));
    dp_ready = 1'b1;
    tick();
    dp_ready = 1'b0;
    check("ar_resume_count", count, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
